fft_result_streamer: RTL and testbench

- Reader-side counterpart to the 64-point FFT stage router. Once the final butterfly stage settles, it captures the full parallel bank of 64 complex results in one cycle.
- It then streams the results out one sample per transfer, in natural frequency order, over a valid/ready handshake.
- It sits between the FFT core's final stage outputs and the serial output interface.
- It undoes the DIF bit-reversed output ordering, so downstream logic sees bin 0..63 in sequence.

---
 rtl/fft_result_streamer_if.sv | 30 +++
 rtl/fft_result_streamer.sv | 144 ++++++++++++++
 tb/tb_fft_result_streamer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_result_streamer_if.sv
// Bus between the FFT final-stage bank and the serial result streamer.
// The master side owns the bank, start and outReady. The slave side
// (the streamer) owns the streamed sample, its handshake and status.
interface fft_result_streamer_if #(
    parameter int N_POINTS = 64,
    parameter int DATA_W   = 16
);
    localparam int IDX_W = $clog2(N_POINTS);

    logic                         start;
    logic [N_POINTS*DATA_W-1:0]   inRe;
    logic [N_POINTS*DATA_W-1:0]   inIm;
    logic                         busy;
    logic [DATA_W-1:0]            outRe;
    logic [DATA_W-1:0]            outIm;
    logic [IDX_W-1:0]             outIndex;
    logic                         outValid;
    logic                         outReady;
    logic                         done;

    modport master (
        output start, inRe, inIm, outReady,
        input  busy, outRe, outIm, outIndex, outValid, done
    );

    modport slave (
        input  start, inRe, inIm, outReady,
        output busy, outRe, outIm, outIndex, outValid, done
    );
endinterface

// File: rtl/fft_result_streamer.sv
// Captures the 64-sample complex bank from the last FFT stage in one cycle,
// then streams it out one bin per valid/ready transfer in natural frequency
// order, undoing the DIF bit-reversed slot ordering when BIT_REVERSE is set.
module fft_result_streamer #(
    parameter int N_POINTS    = 64,
    parameter int DATA_W      = 16,
    parameter int BIT_REVERSE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_result_streamer_if.slave  bus
);
    localparam int               IDX_W    = $clog2(N_POINTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  count;
    logic              done_q;
    logic [DATA_W-1:0] bank_re [N_POINTS];
    logic [DATA_W-1:0] bank_im [N_POINTS];

    logic              capture;
    logic              xfer;
    logic              last;
    logic [IDX_W-1:0]  slot;

    // Mirror the index bits: bit b of the result is bit IDX_W-1-b of v.
    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int b = 0; b < IDX_W; b++) begin
            r[b] = v[IDX_W-1-b];
        end
        return r;
    endfunction

    // A start only counts in IDLE; outValid equals (state == STREAM), so a
    // transfer needs only the state and the downstream ready.
    assign capture = (state == IDLE) && bus.start;
    assign xfer    = (state == STREAM) && bus.outReady;
    assign last    = (count == LAST_IDX);
    assign slot    = (BIT_REVERSE != 0) ? bitrev(count) : count;

    // State register.
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values, independent of the order the blocks are evaluated in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: leave IDLE on an accepted start, leave STREAM on the
    // transfer of the final bin.
    // NOTE: the default assignment at the top keeps every path assigned, so
    // no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)   state_nxt = STREAM;
            STREAM:  if (xfer && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: the handshake and status come from registered state
    // only, and the sample is a mux of the bank addressed by the count.
    always_comb begin
        bus.busy     = 1'b0;
        bus.outValid = 1'b0;
        bus.outIndex = '0;
        bus.outRe    = '0;
        bus.outIm    = '0;
        bus.done     = done_q;
        if (state == STREAM) begin
            bus.busy     = 1'b1;
            bus.outValid = 1'b1;
            bus.outIndex = count;
            bus.outRe    = bank_re[slot];
            bus.outIm    = bank_im[slot];
        end
    end

    // Bin counter: cleared on capture, advanced on each transfer, and wrapped
    // back to zero only by the final transfer of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (capture) begin
            count <= '0;
        end else if (xfer) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

    // Single-cycle done pulse following acceptance of the last bin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= xfer && last;
        end
    end

    // Capture buffer: loaded from the whole parallel bank on an accepted
    // start and otherwise left alone, so input changes mid-stream are unseen.
    // NOTE: this storage is deliberately reset to zero because the cleared
    // buffer is part of the defined post-reset state; storage without such a
    // requirement would normally be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_POINTS; i++) begin
                bank_re[i] <= '0;
                bank_im[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < N_POINTS; i++) begin
                bank_re[i] <= bus.inRe[i*DATA_W +: DATA_W];
                bank_im[i] <= bus.inIm[i*DATA_W +: DATA_W];
            end
        end
    end

    // A stalled sample is neither withdrawn nor altered before it transfers.
    a_stall_hold: assert property (
        @(posedge clk) disable iff (rst)
        (bus.outValid && !bus.outReady) |=>
            (bus.outValid && $stable(bus.outIndex) &&
             $stable(bus.outRe) && $stable(bus.outIm))
    );

    // done never lasts longer than one cycle.
    a_done_pulse: assert property (
        @(posedge clk) disable iff (rst)
        bus.done |=> !bus.done
    );
endmodule

// File: tb/tb_fft_result_streamer.sv
// Bench for fft_result_streamer: one bit-reversing instance and one
// natural-order instance share clock and reset. Each start pushes the
// expected 64-bin frame into a queue; a negedge monitor per instance
// compares whatever sample is presented against the queue head and pops it
// on a transfer, then expects done in the cycle after bin 63 is popped.
module tb_fft_result_streamer;
    localparam int N = 64;
    localparam int W = 16;

    typedef struct packed {
        logic [5:0]   idx;
        logic [W-1:0] re;
        logic [W-1:0] im;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_result_streamer_if #(.N_POINTS(N), .DATA_W(W)) b1 ();
    fft_result_streamer_if #(.N_POINTS(N), .DATA_W(W)) b0 ();

    fft_result_streamer #(.N_POINTS(N), .DATA_W(W), .BIT_REVERSE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    fft_result_streamer #(.N_POINTS(N), .DATA_W(W), .BIT_REVERSE(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    int           checks   = 0;
    int           failures = 0;
    exp_t         q1[$];
    exp_t         q0[$];
    bit           due1 = 1'b0;
    bit           due0 = 1'b0;
    logic [W-1:0] bank_re [N];
    logic [W-1:0] bank_im [N];
    logic [W-1:0] tbl [4] = '{16'd0, 16'd32, 16'd16, 16'd48};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [5:0] rev6(input logic [5:0] k);
        logic [5:0] r;
        for (int b = 0; b < 6; b++) r[b] = k[5-b];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_banks();
        for (int i = 0; i < N; i++) begin
            b1.inRe[i*W +: W] = bank_re[i];
            b1.inIm[i*W +: W] = bank_im[i];
            b0.inRe[i*W +: W] = bank_re[i];
            b0.inIm[i*W +: W] = bank_im[i];
        end
    endtask

    task automatic push_frame1();
        for (int k = 0; k < N; k++) begin
            q1.push_back('{idx: 6'(k), re: bank_re[rev6(6'(k))], im: bank_im[rev6(6'(k))]});
        end
    endtask

    task automatic push_frame0();
        for (int k = 0; k < N; k++) begin
            q0.push_back('{idx: 6'(k), re: bank_re[k], im: bank_im[k]});
        end
    endtask

    task automatic pulse_start1();
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
    endtask

    task automatic wait_idx1(input int idx, input string name);
        int n = 0;
        while (!(b1.outValid && b1.outIndex == 6'(idx)) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) timeout(name);
    endtask

    task automatic wait_done1(input string name);
        int n = 0;
        while (!b1.done && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) timeout(name);
    endtask

    task automatic wait_done0(input string name);
        int n = 0;
        while (!b0.done && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) timeout(name);
    endtask

    // Monitor for the bit-reversing instance.
    always @(negedge clk) begin
        exp_t e;
        if (b1.done || due1) begin
            check("dut1 done pulse", b1.done, due1);
            due1 = 1'b0;
        end
        if (b1.outValid) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected valid", b1.outValid, 1'b0);
            end else begin
                e = q1[0];
                check("dut1 index", b1.outIndex, e.idx);
                check("dut1 re", b1.outRe, e.re);
                check("dut1 im", b1.outIm, e.im);
                if (b1.outReady) begin
                    void'(q1.pop_front());
                    if (e.idx == 6'd63) due1 = 1'b1;
                end
            end
        end
    end

    // Monitor for the natural-order instance.
    always @(negedge clk) begin
        exp_t e;
        if (b0.done || due0) begin
            check("dut0 done pulse", b0.done, due0);
            due0 = 1'b0;
        end
        if (b0.outValid) begin
            if (q0.size() == 0) begin
                check("dut0 unexpected valid", b0.outValid, 1'b0);
            end else begin
                e = q0[0];
                check("dut0 index", b0.outIndex, e.idx);
                check("dut0 re", b0.outRe, e.re);
                check("dut0 im", b0.outIm, e.im);
                if (b0.outReady) begin
                    void'(q0.pop_front());
                    if (e.idx == 6'd63) due0 = 1'b1;
                end
            end
        end
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vcnt;
        int n;
        int ph;

        rst        = 1'b1;
        b1.start   = 1'b0;
        b0.start   = 1'b0;
        b1.outReady = 1'b1;
        b0.outReady = 1'b1;
        for (int i = 0; i < N; i++) begin
            bank_re[i] = 16'(i);
            bank_im[i] = 16'(-i);
        end
        drive_banks();

        // Reset state.
        #1;
        check("reset busy", b1.busy, 1'b0);
        check("reset valid", b1.outValid, 1'b0);
        check("reset done", b1.done, 1'b0);
        check("reset index", b1.outIndex, 6'd0);
        check("reset re", b1.outRe, 16'd0);
        check("reset im", b1.outIm, 16'd0);
        check("reset valid dut0", b0.outValid, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Natural stream, bit-reversed readout, ready held high.
        push_frame1();
        pulse_start1();
        for (int k = 0; k < 4; k++) begin
            check("t1 index", b1.outIndex, k);
            check("t1 re", b1.outRe, tbl[k]);
            check("t1 im", b1.outIm, 16'(16'd0 - tbl[k]));
            tick();
        end
        vcnt = 4;
        n    = 0;
        while (b1.outValid && n < 200) begin
            if (b1.outIndex == 6'd63) check("t1 bin63 re", b1.outRe, 16'd63);
            vcnt++;
            n++;
            tick();
        end
        check("t1 valid cycles", vcnt, 64);
        check("t1 done high", b1.done, 1'b1);
        tick();
        check("t1 done width", b1.done, 1'b0);
        check("t1 drained", q1.size(), 0);

        // Backpressure with ready pattern 1,0,0,1.
        push_frame1();
        pulse_start1();
        ph = 0;
        while (!b1.done && ph < 600) begin
            b1.outReady = (ph % 4 == 0) || (ph % 4 == 3);
            ph++;
            tick();
        end
        if (ph >= 600) timeout("t2 done");
        b1.outReady = 1'b1;
        check("t2 drained", q1.size(), 0);
        tick();

        // Input isolation and start ignored mid-stream.
        push_frame1();
        pulse_start1();
        tick();
        for (int i = 0; i < N; i++) b1.inRe[i*W +: W] = 16'hAAAA;
        wait_idx1(20, "t3 reach bin 20");
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        check("t3 index after ignored start", b1.outIndex, 6'd21);
        check("t3 still busy", b1.busy, 1'b1);
        wait_done1("t3 done");
        check("t3 drained", q1.size(), 0);
        drive_banks();
        tick();

        // Asynchronous reset mid-stream, then a fresh capture.
        push_frame1();
        pulse_start1();
        wait_idx1(30, "t4 reach bin 30");
        #2;
        rst = 1'b1;
        q1.delete();
        #1;
        check("t4 valid drops async", b1.outValid, 1'b0);
        check("t4 busy drops async", b1.busy, 1'b0);
        check("t4 index cleared", b1.outIndex, 6'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t4 no done", b1.done, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            bank_re[i] = 16'h0100 + 16'(i);
            bank_im[i] = 16'h8000 | 16'(i);
        end
        drive_banks();
        tick();
        push_frame1();
        pulse_start1();
        check("t4 restart valid", b1.outValid, 1'b1);
        check("t4 restart index", b1.outIndex, 6'd0);
        wait_done1("t4 done");
        check("t4 drained", q1.size(), 0);
        tick();

        // Natural-order instance with back-to-back frames.
        for (int i = 0; i < N; i++) begin
            bank_re[i] = 16'(i);
            bank_im[i] = ~16'(i);
        end
        drive_banks();
        push_frame0();
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        check("t5 first valid", b0.outValid, 1'b1);
        check("t5 first re", b0.outRe, 16'd0);
        wait_done0("t5 first done");
        push_frame0();
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        check("t5 second valid", b0.outValid, 1'b1);
        check("t5 second index", b0.outIndex, 6'd0);
        wait_done0("t5 second done");
        tick();
        tick();
        check("t5 drained", q0.size(), 0);
        check("t5 dut1 idle", b1.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
